// File: rtl/sched_pkg.sv
// sched_pkg
// Shared definitions for the screen scheduler:
//   - VIS_* screen codes driven on the display's visua input
//   - channel index constants (comida, salud, descanso, animo)
//   - scheduler state enum
//   - helpers for the lowest-set-bit and round-robin searches
package sched_pkg;

  localparam int NUM_CH = 4;

  localparam int CH_COMIDA   = 0;
  localparam int CH_SALUD    = 1;
  localparam int CH_DESCANSO = 2;
  localparam int CH_ANIMO    = 3;

  localparam logic [3:0] VIS_IDLE  = 4'd0;
  localparam logic [3:0] VIS_NEED0 = 4'd1;
  localparam logic [3:0] VIS_NEED1 = 4'd2;
  localparam logic [3:0] VIS_NEED2 = 4'd3;
  localparam logic [3:0] VIS_NEED3 = 4'd4;
  localparam logic [3:0] VIS_ACT0  = 4'd5;
  localparam logic [3:0] VIS_ACT1  = 4'd6;
  localparam logic [3:0] VIS_ACT2  = 4'd7;
  localparam logic [3:0] VIS_ACT3  = 4'd8;
  localparam logic [3:0] VIS_TEST  = 4'd9;

  typedef enum logic [1:0] {
    S_PICK     = 2'd0,
    S_WAIT_FRM = 2'd1,
    S_DWELL    = 2'd2
  } sched_state_t;

  // Index of the lowest set bit; 0 when no bit is set (callers gate on |v).
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    lowest_set = 2'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = 2'(k);
    end
  endfunction

  // First set bit searching upward from ptr with wrap 3 -> 0.
  function automatic logic [1:0] rr_first(input logic [3:0] v, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_first = ptr;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!found && v[idx]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sched_ms_tick.sv
// sched_ms_tick
// Free-running millisecond prescaler. Emits a registered one-cycle pulse
// every TICKS_PER_MS clock cycles, counting from reset.
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-low reset
//   o_ms_tick  one-cycle pulse per millisecond
module sched_ms_tick #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_ms_tick
);

  localparam int CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ms_tick;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt     <= '0;
      r_ms_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt     <= '0;
      r_ms_tick <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_ms_tick <= 1'b0;
    end
  end

  assign o_ms_tick = r_ms_tick;

endmodule

// File: rtl/screen_scheduler.sv
// screen_scheduler
// Shares the ILI9341 display between test mode, four active-action screens
// and four need screens. Selection is fixed priority (test > act > need > idle)
// with round-robin among need channels, a minimum dwell per screen and a
// frame-complete handshake with the display.
//
// Optional feature macro: SCHED_FRAME_TIMEOUT_EN
//   defined   -> S_WAIT_FRM gives up after FRAME_TO_MS ms, sets o_timeout_err
//   undefined -> S_WAIT_FRM waits indefinitely, o_timeout_err tied to 0
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-low reset
//   i_test_mode    level, forces the test screen
//   i_act[3:0]     level, action in progress per channel
//   i_req[3:0]     level, channel requests its need screen
//   i_frame_done   one-cycle pulse, display finished a frame
//   o_visua[3:0]   screen code to the display
//   o_upd          one-cycle pulse when o_visua changes
//   o_timeout_err  sticky frame-timeout flag
//
// state      | meaning
// S_PICK     | one-cycle selection; load new screen or re-dwell on same one
// S_WAIT_FRM | new screen issued, waiting for the display to draw it
// S_DWELL    | holding the screen for HOLD_MS ms unless preempted
module screen_scheduler #(
  parameter int TICKS_PER_MS = 50000,
  parameter int HOLD_MS      = 2000,
  parameter int FRAME_TO_MS  = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_test_mode,
  input  logic [3:0] i_act,
  input  logic [3:0] i_req,
  input  logic       i_frame_done,
  output logic [3:0] o_visua,
  output logic       o_upd,
  output logic       o_timeout_err
);
  import sched_pkg::*;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

  sched_state_t r_state;
  logic [3:0]   r_visua;
  logic         r_upd;
  logic [1:0]   r_rr_ptr;
  logic [15:0]  r_dwell;

  logic         w_ms_tick;
  logic [3:0]   w_act_code;
  logic [1:0]   w_need_idx;
  logic [3:0]   w_sel;
  logic         w_sel_need;
  logic         w_preempt;

  sched_ms_tick #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_ms_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_ms_tick (w_ms_tick)
  );

  always_comb begin
    w_act_code = VIS_ACT0 + {2'b00, lowest_set(i_act)};
    w_need_idx = rr_first(i_req, r_rr_ptr);
    w_sel_need = 1'b0;
    if (i_test_mode) begin
      w_sel = VIS_TEST;
    end else if (|i_act) begin
      w_sel = w_act_code;
    end else if (|i_req) begin
      w_sel      = VIS_NEED0 + {2'b00, w_need_idx};
      w_sel_need = 1'b1;
    end else begin
      w_sel = VIS_IDLE;
    end
  end

  // Only something that outranks the screen on display cuts a dwell short.
  // Lower act codes outrank higher ones; any act outranks need/idle screens.
  // Test mode while already showing the test screen lets the dwell run, so
  // dropping test mode is honoured only after the dwell completes.
  always_comb begin
    w_preempt = 1'b0;
    if (r_visua != VIS_TEST) begin
      if (i_test_mode) begin
        w_preempt = 1'b1;
      end else if ((|i_act) && ((r_visua < VIS_ACT0) || (w_act_code < r_visua))) begin
        w_preempt = 1'b1;
      end
    end
  end

`ifdef SCHED_FRAME_TIMEOUT_EN
  localparam logic [15:0] FRM_TO_LAST = 16'(FRAME_TO_MS - 1);

  logic [15:0] r_frm_cnt;
  logic        r_timeout_err;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_PICK;
      r_visua       <= VIS_IDLE;
      r_upd         <= 1'b0;
      r_rr_ptr      <= 2'd0;
      r_dwell       <= 16'd0;
      r_frm_cnt     <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        S_PICK: begin
          if (w_sel_need) r_rr_ptr <= w_need_idx + 2'd1;
          if (w_sel != r_visua) begin
            r_visua   <= w_sel;
            r_upd     <= 1'b1;
            r_frm_cnt <= 16'd0;
            r_state   <= S_WAIT_FRM;
          end else begin
            r_dwell <= 16'd0;
            r_state <= S_DWELL;
          end
        end
        S_WAIT_FRM: begin
          // A frame_done coincident with upd belongs to the previous screen.
          if (i_frame_done && !r_upd) begin
            r_dwell <= 16'd0;
            r_state <= S_DWELL;
          end else if (w_ms_tick) begin
            if (r_frm_cnt == FRM_TO_LAST) begin
              r_timeout_err <= 1'b1;
              r_dwell       <= 16'd0;
              r_state       <= S_DWELL;
            end else begin
              r_frm_cnt <= r_frm_cnt + 16'd1;
            end
          end
        end
        S_DWELL: begin
          if (w_preempt) begin
            r_state <= S_PICK;
          end else if (w_ms_tick) begin
            if (r_dwell == HOLD_LAST) r_state <= S_PICK;
            else                      r_dwell <= r_dwell + 16'd1;
          end
        end
        default: r_state <= S_PICK;
      endcase
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  // FRAME_TO_MS has no role when the frame timeout is compiled out.
  localparam int UNUSED_FRAME_TO_MS = FRAME_TO_MS;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_PICK;
      r_visua  <= VIS_IDLE;
      r_upd    <= 1'b0;
      r_rr_ptr <= 2'd0;
      r_dwell  <= 16'd0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        S_PICK: begin
          if (w_sel_need) r_rr_ptr <= w_need_idx + 2'd1;
          if (w_sel != r_visua) begin
            r_visua <= w_sel;
            r_upd   <= 1'b1;
            r_state <= S_WAIT_FRM;
          end else begin
            r_dwell <= 16'd0;
            r_state <= S_DWELL;
          end
        end
        S_WAIT_FRM: begin
          // A frame_done coincident with upd belongs to the previous screen.
          if (i_frame_done && !r_upd) begin
            r_dwell <= 16'd0;
            r_state <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (w_preempt) begin
            r_state <= S_PICK;
          end else if (w_ms_tick) begin
            if (r_dwell == HOLD_LAST) r_state <= S_PICK;
            else                      r_dwell <= r_dwell + 16'd1;
          end
        end
        default: r_state <= S_PICK;
      endcase
    end
  end

  assign o_timeout_err = 1'b0;
`endif

  assign o_visua = r_visua;
  assign o_upd   = r_upd;

endmodule
